cv32e40p_alu_fault_monitor: RTL and testbench

CV32E40P_ALU_FAULT_MONITOR -- requirements
Module: cv32e40p_alu_fault_monitor

---
 rtl/cv32e40p_pkg.sv | 32 +++
 rtl/cv32e40p_alu_fault_monitor_if.sv | 24 ++
 rtl/cv32e40p_fault_leaky_counter.sv | 55 +++++
 rtl/cv32e40p_alu_fault_monitor.sv | 124 ++++++++++++
 tb/tb_cv32e40p_alu_fault_monitor.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and helpers for the TMR ALU fault monitor.
// State encoding is fixed because software reads state_o directly.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULTED = 2'd2,
        MULTI   = 2'd3
    } alu_fault_state_e;

    localparam logic [1:0] SPARE_NONE = 2'd0;

    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // Replica index k maps to spare selection k+1; lowest set bit wins.
    function automatic logic [1:0] onehot_to_spare(input logic [2:0] v);
        logic [1:0] sel;
        sel = SPARE_NONE;
        if (v[0]) begin
            sel = 2'd1;
        end else if (v[1]) begin
            sel = 2'd2;
        end else if (v[2]) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cv32e40p_alu_fault_monitor_if.sv
// Voter-side inputs and status outputs of the ALU fault monitor.
interface cv32e40p_alu_fault_monitor_if #(
    parameter int CNT_W = 8
);
    logic                 sample_i;
    logic [2:0]           error_detected_alu_i;
    logic [2:0]           mismatch_i;
    logic                 clear_i;
    logic [1:0]           state_o;
    logic [1:0]           spare_sel_o;
    logic                 fault_irq_o;
    logic [3*CNT_W-1:0]   err_cnt_o;
    logic [15:0]          total_err_o;

    modport master (
        output sample_i, error_detected_alu_i, mismatch_i, clear_i,
        input  state_o, spare_sel_o, fault_irq_o, err_cnt_o, total_err_o
    );

    modport slave (
        input  sample_i, error_detected_alu_i, mismatch_i, clear_i,
        output state_o, spare_sel_o, fault_irq_o, err_cnt_o, total_err_o
    );
endinterface

// File: rtl/cv32e40p_fault_leaky_counter.sv
// Saturating per-replica error counter that leaks one count after a
// run of DECAY_LEN clean samples.
module cv32e40p_fault_leaky_counter #(
    parameter int CNT_W     = 8,
    parameter int DECAY_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  logic             hit,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0]       DECAY_C = 8'(DECAY_LEN);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       run_reg, run_next;

    // A hit always resets the clean run, so increment naturally beats decay.
    always_comb begin
        cnt_next = cnt_reg;
        run_next = run_reg;
        if (update) begin
            if (hit) begin
                run_next = '0;
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else if (run_reg + 8'd1 == DECAY_C) begin
                run_next = '0;
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end else begin
                run_next = run_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_reg <= '0;
            run_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            run_reg <= run_next;
        end
    end

    assign cnt_o      = cnt_reg;
    assign cnt_next_o = cnt_next;

endmodule

// File: rtl/cv32e40p_alu_fault_monitor.sv
// Tracks per-replica disagreement of the TMR ALU, selects a spare for a
// persistently faulty replica and escalates to MULTI when isolation fails.
module cv32e40p_alu_fault_monitor
    import cv32e40p_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int THRESHOLD = 4,
    parameter int DECAY_LEN = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cv32e40p_alu_fault_monitor_if.slave   mon
);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);

    alu_fault_state_e state_reg, state_next;
    logic [1:0]       spare_sel_reg, spare_sel_next;
    logic             fault_irq_reg, fault_irq_next;
    logic [15:0]      total_err_reg, total_err_next;

    logic [1:0]       hit_count;
    logic             single_hit, multi_hit, cnt_update;
    logic [CNT_W-1:0] err_cnt [3];
    logic [CNT_W-1:0] err_cnt_next [3];
    logic [2:0]       at_thresh, zero_next, isolated_mask;
    logic [3*CNT_W-1:0] err_cnt_flat;

    assign hit_count  = count_ones3(mon.mismatch_i);
    assign single_hit = (hit_count == 2'd1);
    assign multi_hit  = (hit_count >= 2'd2);
    // Counters freeze while a replica is isolated and on multi-replica samples.
    assign cnt_update = mon.sample_i && !mon.clear_i && (state_reg != FAULTED) && !multi_hit;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_replica
            cv32e40p_fault_leaky_counter #(
                .CNT_W     (CNT_W),
                .DECAY_LEN (DECAY_LEN)
            ) u_cnt (
                .clk        (clk),
                .rst_n      (rst_n),
                .clear      (mon.clear_i),
                .update     (cnt_update),
                .hit        (mon.mismatch_i[gi]),
                .cnt_o      (err_cnt[gi]),
                .cnt_next_o (err_cnt_next[gi])
            );
        end
    endgenerate

    always_comb begin
        at_thresh     = '0;
        zero_next     = '0;
        isolated_mask = '0;
        err_cnt_flat  = '0;
        for (int i = 0; i < 3; i++) begin
            at_thresh[i]                  = mon.mismatch_i[i] && (err_cnt_next[i] >= THRESH_C);
            zero_next[i]                  = (err_cnt_next[i] == '0);
            isolated_mask[i]              = (spare_sel_reg == 2'(i + 1));
            err_cnt_flat[i*CNT_W +: CNT_W] = err_cnt[i];
        end
    end

    always_comb begin
        state_next     = state_reg;
        spare_sel_next = spare_sel_reg;
        fault_irq_next = 1'b0;
        total_err_next = total_err_reg;
        if (mon.sample_i) begin
            if ((|mon.error_detected_alu_i) && (total_err_reg != 16'hFFFF)) begin
                total_err_next = total_err_reg + 16'd1;
            end
            case (state_reg)
                OK, SUSPECT: begin
                    if (multi_hit) begin
                        state_next     = MULTI;
                        fault_irq_next = 1'b1;
                    end else if (single_hit) begin
                        if (|at_thresh) begin
                            state_next     = FAULTED;
                            spare_sel_next = onehot_to_spare(mon.mismatch_i);
                            fault_irq_next = 1'b1;
                        end else begin
                            state_next = SUSPECT;
                        end
                    end else if (&zero_next) begin
                        state_next = OK;
                    end
                end
                FAULTED: begin
                    // Anything other than the already-isolated replica disagreeing is unrecoverable.
                    if (|(mon.mismatch_i & ~isolated_mask)) begin
                        state_next     = MULTI;
                        fault_irq_next = 1'b1;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || mon.clear_i) begin
            state_reg     <= OK;
            spare_sel_reg <= SPARE_NONE;
            fault_irq_reg <= 1'b0;
            total_err_reg <= '0;
        end else begin
            state_reg     <= state_next;
            spare_sel_reg <= spare_sel_next;
            fault_irq_reg <= fault_irq_next;
            total_err_reg <= total_err_next;
        end
    end

    assign mon.state_o     = state_reg;
    assign mon.spare_sel_o = spare_sel_reg;
    assign mon.fault_irq_o = fault_irq_reg;
    assign mon.err_cnt_o   = err_cnt_flat;
    assign mon.total_err_o = total_err_reg;

endmodule

// File: tb/tb_cv32e40p_alu_fault_monitor.sv
// Directed and randomized checks of the ALU fault monitor against a
// sample-level behavioural model.
module tb_cv32e40p_alu_fault_monitor;

    localparam int CNT_W  = 8;
    localparam int THRESH = 4;
    localparam int DECAY  = 8;
    localparam int CMAX   = 255;
    localparam int S_OK = 0, S_SUSPECT = 1, S_FAULTED = 2, S_MULTI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total_checks = 0;
    int   bad = 0;

    cv32e40p_alu_fault_monitor_if #(.CNT_W(CNT_W)) bus ();

    cv32e40p_alu_fault_monitor #(
        .CNT_W     (CNT_W),
        .THRESHOLD (THRESH),
        .DECAY_LEN (DECAY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: one call per clock edge.
    int m_cnt [3];
    int m_run [3];
    int m_state, m_spare, m_total;
    bit m_irq;

    function automatic void model_step(input bit rstn, input bit smp, input bit [2:0] err,
                                       input bit [2:0] mm, input bit clr);
        int nbits;
        int hit_idx;
        int sum;
        bit [2:0] others;
        m_irq = 1'b0;
        if (!rstn || clr) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0;
                m_run[i] = 0;
            end
            m_state = S_OK;
            m_spare = 0;
            m_total = 0;
            return;
        end
        if (!smp) return;
        if (err != 3'b000 && m_total < 65535) m_total++;
        nbits = $countones(mm);
        if (m_state == S_FAULTED) begin
            others = mm;
            others[m_spare - 1] = 1'b0;
            if (others != 3'b000) begin
                m_state = S_MULTI;
                m_irq   = 1'b1;
            end
            return;
        end
        if (nbits >= 2) begin
            if (m_state != S_MULTI) begin
                m_state = S_MULTI;
                m_irq   = 1'b1;
            end
            return;
        end
        hit_idx = 0;
        for (int i = 0; i < 3; i++) begin
            if (mm[i]) begin
                m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                m_run[i] = 0;
                hit_idx  = i;
            end else begin
                m_run[i]++;
                if (m_run[i] == DECAY) begin
                    m_run[i] = 0;
                    if (m_cnt[i] > 0) m_cnt[i]--;
                end
            end
        end
        if (m_state == S_MULTI) return;
        sum = m_cnt[0] + m_cnt[1] + m_cnt[2];
        if (nbits == 1) begin
            if (m_cnt[hit_idx] >= THRESH) begin
                m_state = S_FAULTED;
                m_spare = hit_idx + 1;
                m_irq   = 1'b1;
            end else begin
                m_state = S_SUSPECT;
            end
        end else if (sum == 0) begin
            m_state = S_OK;
        end
    endfunction

    task automatic drive(input bit smp, input bit [2:0] err, input bit [2:0] mm, input bit clr);
        bus.sample_i             = smp;
        bus.error_detected_alu_i = err;
        bus.mismatch_i           = mm;
        bus.clear_i              = clr;
        @(posedge clk);
        #1;
        model_step(rst_n, smp, err, mm, clr);
        bus.sample_i             = 1'b0;
        bus.error_detected_alu_i = 3'b000;
        bus.mismatch_i           = 3'b000;
        bus.clear_i              = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 3'b001, 3'b010, 1'b0);
        drive(1'b1, 3'b001, 3'b010, 1'b0);
        total_checks++;
        if (bus.state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state_o); end
        total_checks++;
        if (bus.spare_sel_o !== 2'd0) begin bad++; $display("FAIL reset_spare got=%0d want=0", bus.spare_sel_o); end
        total_checks++;
        if (bus.fault_irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b want=0", bus.fault_irq_o); end
        total_checks++;
        if (bus.err_cnt_o !== '0) begin bad++; $display("FAIL reset_cnt got=%h want=0", bus.err_cnt_o); end
        total_checks++;
        if (bus.total_err_o !== 16'd0) begin bad++; $display("FAIL reset_total got=%0d want=0", bus.total_err_o); end
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_fault_entry();
        int irq_seen = 0;
        for (int n = 1; n <= 4; n++) begin
            drive(1'b1, 3'b000, 3'b010, 1'b0);
            irq_seen += int'(bus.fault_irq_o);
            total_checks++;
            if (bus.state_o !== ((n < 4) ? 2'd1 : 2'd2)) begin
                bad++; $display("FAIL entry_state n=%0d got=%0d want=%0d", n, bus.state_o, (n < 4) ? 1 : 2);
            end
            total_checks++;
            if (bus.err_cnt_o[15:8] !== 8'(n)) begin
                bad++; $display("FAIL entry_cnt1 n=%0d got=%0d want=%0d", n, bus.err_cnt_o[15:8], n);
            end
        end
        total_checks++;
        if (bus.spare_sel_o !== 2'd2) begin bad++; $display("FAIL entry_spare got=%0d want=2", bus.spare_sel_o); end
        total_checks++;
        if (bus.fault_irq_o !== 1'b1) begin bad++; $display("FAIL entry_irq_edge got=%0b want=1", bus.fault_irq_o); end
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        irq_seen += int'(bus.fault_irq_o);
        drive(1'b1, 3'b000, 3'b010, 1'b0);
        irq_seen += int'(bus.fault_irq_o);
        total_checks++;
        if (irq_seen != 1) begin bad++; $display("FAIL entry_irq_pulses got=%0d want=1", irq_seen); end
        total_checks++;
        if (bus.state_o !== 2'd2) begin bad++; $display("FAIL entry_hold got=%0d want=2", bus.state_o); end
        drive(1'b0, 3'b000, 3'b000, 1'b1);
        $display("test_fault_entry done");
    endtask

    task automatic test_decay();
        drive(1'b1, 3'b000, 3'b001, 1'b0);
        drive(1'b1, 3'b000, 3'b001, 1'b0);
        total_checks++;
        if (bus.err_cnt_o[7:0] !== 8'd2) begin bad++; $display("FAIL decay_start got=%0d want=2", bus.err_cnt_o[7:0]); end
        for (int n = 1; n <= 16; n++) begin
            drive(1'b1, 3'b000, 3'b000, 1'b0);
            if (n == 7 || n == 8 || n == 15 || n == 16) begin
                total_checks++;
                if (bus.err_cnt_o[7:0] !== ((n < 8) ? 8'd2 : (n < 16) ? 8'd1 : 8'd0)) begin
                    bad++; $display("FAIL decay_cnt0 n=%0d got=%0d", n, bus.err_cnt_o[7:0]);
                end
                total_checks++;
                if (bus.state_o !== ((n < 16) ? 2'd1 : 2'd0)) begin
                    bad++; $display("FAIL decay_state n=%0d got=%0d", n, bus.state_o);
                end
            end
        end
        $display("test_decay done");
    endtask

    task automatic test_multi();
        drive(1'b1, 3'b011, 3'b011, 1'b0);
        total_checks++;
        if (bus.state_o !== 2'd3) begin bad++; $display("FAIL multi_state got=%0d want=3", bus.state_o); end
        total_checks++;
        if (bus.fault_irq_o !== 1'b1) begin bad++; $display("FAIL multi_irq got=%0b want=1", bus.fault_irq_o); end
        for (int n = 0; n < 10; n++) drive(1'b1, 3'b000, 3'b000, 1'b0);
        total_checks++;
        if (bus.state_o !== 2'd3 || bus.fault_irq_o !== 1'b0) begin
            bad++; $display("FAIL multi_sticky state=%0d irq=%0b want=3/0", bus.state_o, bus.fault_irq_o);
        end
        drive(1'b0, 3'b000, 3'b000, 1'b1);
        total_checks++;
        if (bus.state_o !== 2'd0 || bus.err_cnt_o !== '0 || bus.spare_sel_o !== 2'd0) begin
            bad++; $display("FAIL multi_clear state=%0d cnt=%h spare=%0d want=0", bus.state_o, bus.err_cnt_o, bus.spare_sel_o);
        end
        $display("test_multi done");
    endtask

    task automatic test_faulted_isolation();
        for (int n = 0; n < 4; n++) drive(1'b1, 3'b000, 3'b001, 1'b0);
        total_checks++;
        if (bus.state_o !== 2'd2 || bus.spare_sel_o !== 2'd1) begin
            bad++; $display("FAIL iso_enter state=%0d spare=%0d want=2/1", bus.state_o, bus.spare_sel_o);
        end
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 3'b001, 3'b001, 1'b0);
            total_checks++;
            if (bus.state_o !== 2'd2 || bus.err_cnt_o[7:0] !== 8'd4 || bus.fault_irq_o !== 1'b0) begin
                bad++; $display("FAIL iso_ignore state=%0d cnt0=%0d irq=%0b want=2/4/0",
                                bus.state_o, bus.err_cnt_o[7:0], bus.fault_irq_o);
            end
        end
        drive(1'b1, 3'b000, 3'b100, 1'b0);
        total_checks++;
        if (bus.state_o !== 2'd3 || bus.spare_sel_o !== 2'd1 || bus.fault_irq_o !== 1'b1) begin
            bad++; $display("FAIL iso_escalate state=%0d spare=%0d irq=%0b want=3/1/1",
                            bus.state_o, bus.spare_sel_o, bus.fault_irq_o);
        end
        drive(1'b0, 3'b000, 3'b000, 1'b1);
        $display("test_faulted_isolation done");
    endtask

    task automatic test_clear_and_reset();
        drive(1'b1, 3'b001, 3'b001, 1'b0);
        drive(1'b1, 3'b001, 3'b001, 1'b1);
        total_checks++;
        if (bus.err_cnt_o !== '0 || bus.state_o !== 2'd0 || bus.total_err_o !== 16'd0) begin
            bad++; $display("FAIL clear_wins cnt=%h state=%0d total=%0d want=0", bus.err_cnt_o, bus.state_o, bus.total_err_o);
        end
        for (int n = 0; n < 4; n++) drive(1'b1, 3'b100, 3'b010, 1'b0);
        total_checks++;
        if (bus.state_o !== 2'd2) begin bad++; $display("FAIL rst_pre state=%0d want=2", bus.state_o); end
        rst_n = 1'b0;
        drive(1'b1, 3'b001, 3'b001, 1'b0);
        rst_n = 1'b1;
        total_checks++;
        if (bus.state_o !== 2'd0 || bus.spare_sel_o !== 2'd0 || bus.fault_irq_o !== 1'b0 ||
            bus.err_cnt_o !== '0 || bus.total_err_o !== 16'd0) begin
            bad++; $display("FAIL rst_faulted state=%0d spare=%0d irq=%0b cnt=%h total=%0d want all 0",
                            bus.state_o, bus.spare_sel_o, bus.fault_irq_o, bus.err_cnt_o, bus.total_err_o);
        end
        $display("test_clear_and_reset done");
    endtask

    task automatic test_random();
        bit smp, clr, rst;
        bit [2:0] err, mm;
        int r, fav;
        for (int n = 0; n < 3000; n++) begin
            fav = (n / 400) % 3;
            smp = ($urandom_range(0, 3) != 0);
            err = 3'($urandom_range(0, 7));
            r   = $urandom_range(0, 99);
            if (r < 55)      mm = 3'b000;
            else if (r < 80) mm = 3'b001 << fav;
            else if (r < 97) mm = 3'b001 << $urandom_range(0, 2);
            else             mm = 3'b111 ^ (3'b001 << $urandom_range(0, 3));
            clr = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 399) == 0);
            rst_n = !rst;
            drive(smp, err, mm, clr);
            rst_n = 1'b1;
            total_checks++;
            if (bus.state_o !== 2'(m_state) || bus.spare_sel_o !== 2'(m_spare) || bus.fault_irq_o !== m_irq) begin
                bad++; $display("FAIL rand_status n=%0d got=%0d/%0d/%0b want=%0d/%0d/%0b", n,
                                bus.state_o, bus.spare_sel_o, bus.fault_irq_o, m_state, m_spare, m_irq);
            end
            for (int i = 0; i < 3; i++) begin
                total_checks++;
                if (bus.err_cnt_o[i*CNT_W +: CNT_W] !== 8'(m_cnt[i])) begin
                    bad++; $display("FAIL rand_cnt%0d n=%0d got=%0d want=%0d", i, n,
                                    bus.err_cnt_o[i*CNT_W +: CNT_W], m_cnt[i]);
                end
            end
            total_checks++;
            if (bus.total_err_o !== 16'(m_total)) begin
                bad++; $display("FAIL rand_total n=%0d got=%0d want=%0d", n, bus.total_err_o, m_total);
            end
        end
        $display("test_random done");
    endtask

    task automatic test_total_saturation();
        drive(1'b0, 3'b000, 3'b000, 1'b1);
        bus.sample_i             = 1'b1;
        bus.error_detected_alu_i = 3'b001;
        bus.mismatch_i           = 3'b000;
        repeat (65534) @(posedge clk);
        #1;
        total_checks++;
        if (bus.total_err_o !== 16'd65534) begin bad++; $display("FAIL sat_pre got=%0d want=65534", bus.total_err_o); end
        @(posedge clk);
        #1;
        total_checks++;
        if (bus.total_err_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h want=FFFF", bus.total_err_o); end
        repeat (70000 - 65535) @(posedge clk);
        #1;
        total_checks++;
        if (bus.total_err_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=FFFF", bus.total_err_o); end
        bus.sample_i             = 1'b0;
        bus.error_detected_alu_i = 3'b000;
        $display("test_total_saturation done");
    endtask

    initial begin
        bus.sample_i             = 1'b0;
        bus.error_detected_alu_i = 3'b000;
        bus.mismatch_i           = 3'b000;
        bus.clear_i              = 1'b0;
        test_reset();
        test_fault_entry();
        test_decay();
        test_multi();
        test_faulted_isolation();
        test_clear_and_reset();
        test_random();
        test_total_saturation();
        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

endmodule
